// File: rtl/jt51_pg_pkg.sv
// Shared definitions for the JT51 phase-generator slot controller: field codes,
// per-field widths, slot count and pipeline stage offsets.
package jt51_pg_pkg;

    localparam int SLOT_N  = 32;
    localparam int STG_II  = 1;
    localparam int STG_III = 2;
    localparam int STG_VI  = 5;

    localparam int KC_W  = 7;
    localparam int KF_W  = 6;
    localparam int DT1_W = 3;
    localparam int MUL_W = 4;
    localparam int DT2_W = 2;
    localparam int PMS_W = 3;

    localparam logic [2:0] FLD_KC     = 3'd0;
    localparam logic [2:0] FLD_KF     = 3'd1;
    localparam logic [2:0] FLD_DT1MUL = 3'd2;
    localparam logic [2:0] FLD_DT2    = 3'd3;
    localparam logic [2:0] FLD_PMS    = 3'd4;

    typedef struct packed {
        logic [KC_W-1:0]  kc;
        logic [KF_W-1:0]  kf;
        logic [DT1_W-1:0] dt1;
        logic [MUL_W-1:0] mul;
        logic [DT2_W-1:0] dt2;
        logic [PMS_W-1:0] pms;
    } pg_param_t;

    // Packs one stored field into the 7-bit write/read data layout.
    function automatic logic [6:0] pg_field_read(input pg_param_t p, input logic [2:0] f);
        logic [6:0] v;
        v = 7'd0;
        case (f)
            FLD_KC:     v = p.kc;
            FLD_KF:     v = {1'b0, p.kf};
            FLD_DT1MUL: v = {p.dt1, p.mul};
            FLD_DT2:    v = {5'd0, p.dt2};
            FLD_PMS:    v = {4'd0, p.pms};
            default:    v = 7'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/jt51_sh.sv
// Clock-enabled shift register used to align per-slot values to later PG stages.
module jt51_sh #(
    parameter int width  = 5,
    parameter int stages = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [width-1:0] din,
    output logic [width-1:0] drop
);

    logic [width-1:0] bits_r [0:stages-1];

    // Shift chain, cleared asynchronously so no stale value leaks past reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < stages; i++) bits_r[i] <= '0;
        end else if (cen) begin
            bits_r[0] <= din;
            for (int i = 1; i < stages; i++) bits_r[i] <= bits_r[i-1];
        end
    end

    assign drop = bits_r[stages-1];

endmodule

// File: rtl/jt51_pg_slot_ctrl.sv
// JT51 PG slot controller: slot sequencing, per-slot parameter store and key-on reset pulses.
// Optional readback port enabled by defining JT51_PGCTL_READBACK_EN.
module jt51_pg_slot_ctrl
    import jt51_pg_pkg::*;
#(
    parameter int PG_RST_ROUNDS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_slot,
    input  logic [2:0] wr_field,
    input  logic [6:0] wr_data,
    input  logic       keyon_req,
    input  logic [4:0] keyon_slot,
    output logic       zero,
    output logic [4:0] slot_I,
    output logic [6:0] kc_I,
    output logic [5:0] kf_I,
    output logic [1:0] dt2_I,
    output logic [2:0] pms_I,
    output logic [2:0] dt1_II,
    output logic [3:0] mul_VI,
    output logic       pg_rst_III
`ifdef JT51_PGCTL_READBACK_EN
    ,
    input  logic [4:0] rd_slot,
    input  logic [2:0] rd_field,
    output logic [6:0] rd_data
`endif
);

    localparam logic [1:0] ROUNDS    = 2'(PG_RST_ROUNDS);
    localparam logic [1:0] ROUNDS_M1 = 2'(PG_RST_ROUNDS - 1);

    logic [4:0]       cnt_r;
    pg_param_t        store_r [0:SLOT_N-1];
    logic [1:0]       pend_r  [0:SLOT_N-1];
    logic [DT1_W-1:0] dt1_I_r;
    logic [MUL_W-1:0] mul_I_r;
    logic             pg_rst_I_r;
    pg_param_t        cur_s;
    logic             wr_en_s;

    assign cur_s    = store_r[cnt_r];
    assign wr_ready = rst_n & cen & (wr_slot != cnt_r);
    assign wr_en_s  = wr_valid & wr_ready;

    // Parameter store writes; the slot being read this cycle is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_N; i++) store_r[i] <= '0;
        end else if (wr_en_s) begin
            case (wr_field)
                FLD_KC:     store_r[wr_slot].kc <= wr_data[6:0];
                FLD_KF:     store_r[wr_slot].kf <= wr_data[5:0];
                FLD_DT1MUL: {store_r[wr_slot].dt1, store_r[wr_slot].mul} <= wr_data[6:0];
                FLD_DT2:    store_r[wr_slot].dt2 <= wr_data[1:0];
                FLD_PMS:    store_r[wr_slot].pms <= wr_data[2:0];
                default:    ;
            endcase
        end
    end

    // Slot counter and stage-I parameter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 5'd0;
            slot_I  <= 5'd0;
            zero    <= 1'b0;
            kc_I    <= 7'd0;
            kf_I    <= 6'd0;
            dt2_I   <= 2'd0;
            pms_I   <= 3'd0;
            dt1_I_r <= 3'd0;
            mul_I_r <= 4'd0;
        end else if (cen) begin
            cnt_r   <= cnt_r + 5'd1;
            slot_I  <= cnt_r;
            zero    <= (cnt_r == 5'd0);
            kc_I    <= cur_s.kc;
            kf_I    <= cur_s.kf;
            dt2_I   <= cur_s.dt2;
            pms_I   <= cur_s.pms;
            dt1_I_r <= cur_s.dt1;
            mul_I_r <= cur_s.mul;
        end
    end

    // Key-on bookkeeping: a key-on on the slot being read fires now and reloads the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_N; i++) pend_r[i] <= 2'd0;
            pg_rst_I_r <= 1'b0;
        end else if (cen) begin
            if (keyon_req && (keyon_slot == cnt_r)) begin
                pg_rst_I_r    <= 1'b1;
                pend_r[cnt_r] <= ROUNDS_M1;
            end else begin
                pg_rst_I_r <= (pend_r[cnt_r] != 2'd0);
                if (pend_r[cnt_r] != 2'd0) pend_r[cnt_r] <= pend_r[cnt_r] - 2'd1;
                if (keyon_req) pend_r[keyon_slot] <= ROUNDS;
            end
        end
    end

    jt51_sh #(.width(DT1_W), .stages(STG_II)) u_dt1_sh (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(dt1_I_r), .drop(dt1_II)
    );

    jt51_sh #(.width(1), .stages(STG_III)) u_pgrst_sh (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(pg_rst_I_r), .drop(pg_rst_III)
    );

    jt51_sh #(.width(MUL_W), .stages(STG_VI)) u_mul_sh (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(mul_I_r), .drop(mul_VI)
    );

`ifdef JT51_PGCTL_READBACK_EN
    // Registered readback, independent of cen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 7'd0;
        end else begin
            rd_data <= pg_field_read(store_r[rd_slot], rd_field);
        end
    end
`endif

endmodule

// File: tb/tb_jt51_pg_slot_ctrl.sv
// Self-checking bench for jt51_pg_slot_ctrl: per-slot history model plus directed checks.
module tb_jt51_pg_slot_ctrl;

    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       wr_valid = 1'b0;
    logic [4:0] wr_slot = 5'd0;
    logic [2:0] wr_field = 3'd0;
    logic [6:0] wr_data = 7'd0;
    logic       keyon_req = 1'b0;
    logic [4:0] keyon_slot = 5'd0;
    logic       wr_ready, zero, pg_rst_III;
    logic [4:0] slot_I;
    logic [6:0] kc_I;
    logic [5:0] kf_I;
    logic [1:0] dt2_I;
    logic [2:0] pms_I, dt1_II;
    logic [3:0] mul_VI;

    jt51_pg_slot_ctrl #(.PG_RST_ROUNDS(R)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
        .wr_field(wr_field), .wr_data(wr_data),
        .keyon_req(keyon_req), .keyon_slot(keyon_slot),
        .zero(zero), .slot_I(slot_I), .kc_I(kc_I), .kf_I(kf_I),
        .dt2_I(dt2_I), .pms_I(pms_I), .dt1_II(dt1_II), .mul_VI(mul_VI),
        .pg_rst_III(pg_rst_III)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each slot's parameters are, how many reset rounds remain,
    // and a record of what was read at each recent cen.
    typedef struct {
        int slot, kc, kf, dt1, mul, dt2, pms, pg;
    } rec_t;

    rec_t hist[$];
    int m_cnt;
    int m_kc[32], m_kf[32], m_dt1[32], m_mul[32], m_dt2[32], m_pms[32], m_pend[32];

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            m_kc[i] = 0; m_kf[i] = 0; m_dt1[i] = 0; m_mul[i] = 0;
            m_dt2[i] = 0; m_pms[i] = 0; m_pend[i] = 0;
        end
        hist.delete();
    endtask

    task automatic model_cen();
        rec_t r;
        if (!(rst_n && cen)) return;
        r.slot = m_cnt;
        r.kc = m_kc[m_cnt]; r.kf = m_kf[m_cnt]; r.dt1 = m_dt1[m_cnt];
        r.mul = m_mul[m_cnt]; r.dt2 = m_dt2[m_cnt]; r.pms = m_pms[m_cnt];
        if (keyon_req && int'(keyon_slot) == m_cnt) begin
            r.pg = 1;
            m_pend[m_cnt] = R - 1;
        end else begin
            r.pg = (m_pend[m_cnt] > 0) ? 1 : 0;
            if (r.pg == 1) m_pend[m_cnt] = m_pend[m_cnt] - 1;
            if (keyon_req) m_pend[keyon_slot] = R;
        end
        if (wr_valid && int'(wr_slot) != m_cnt) begin
            case (wr_field)
                3'd0: m_kc[wr_slot] = wr_data;
                3'd1: m_kf[wr_slot] = wr_data % 64;
                3'd2: begin m_dt1[wr_slot] = wr_data / 16; m_mul[wr_slot] = wr_data % 16; end
                3'd3: m_dt2[wr_slot] = wr_data % 4;
                3'd4: m_pms[wr_slot] = wr_data % 8;
                default: ;
            endcase
        end
        hist.push_back(r);
        if (hist.size() > 8) void'(hist.pop_front());
        m_cnt = (m_cnt + 1) % 32;
    endtask

    function automatic rec_t back(int k);
        rec_t z = '{default: 0};
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return z;
    endfunction

    rec_t e0, e1, e2, e5;

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        e0 = back(0); e1 = back(1); e2 = back(2); e5 = back(5);
        chk("slot_I", slot_I, e0.slot);
        chk("zero", zero, (hist.size() > 0 && e0.slot == 0) ? 1 : 0);
        chk("kc_I", kc_I, e0.kc);
        chk("kf_I", kf_I, e0.kf);
        chk("dt2_I", dt2_I, e0.dt2);
        chk("pms_I", pms_I, e0.pms);
        chk("dt1_II", dt1_II, e1.dt1);
        chk("pg_rst_III", pg_rst_III, e2.pg);
        chk("mul_VI", mul_VI, e5.mul);
        chk("wr_ready", wr_ready, (rst_n && cen && int'(wr_slot) != m_cnt) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        model_cen();
        #2;
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 40 && m_cnt != c; i++) tick();
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 40 && int'(slot_I) != s; i++) tick();
        chk("wait_slot", slot_I, s);
    endtask

    task automatic do_write(input int s, input int f, input int d);
        if (m_cnt == s) tick();
        wr_valid = 1'b1; wr_slot = 5'(s); wr_field = 3'(f); wr_data = 7'(d);
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        model_reset();
        cen = 1'b1;
        repeat (3) tick();
        chk("reset_slot", slot_I, 0);
        chk("reset_zero", zero, 0);
        chk("reset_ready", wr_ready, 0);
        rst_n = 1'b1;

        // Steady sequencing after reset
        for (int i = 0; i < 65; i++) begin
            tick();
            chk("seq_slot", slot_I, i % 32);
            chk("seq_zero", zero, (i % 32 == 0) ? 1 : 0);
            chk("seq_kc", kc_I, 0);
        end

        // Inputs are ignored while cen is low
        cen = 1'b0;
        wr_valid = 1'b1; wr_slot = 5'd20; wr_field = 3'd0; wr_data = 7'h7F;
        keyon_req = 1'b1; keyon_slot = 5'd21;
        #1 chk("cen_low_ready", wr_ready, 0);
        repeat (3) tick();
        wr_valid = 1'b0; keyon_req = 1'b0; cen = 1'b1;

        // Write slot 5 kc while cnt=10
        wait_cnt(10);
        wr_valid = 1'b1; wr_slot = 5'd5; wr_field = 3'd0; wr_data = 7'h4A;
        #1 chk("w5_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        wait_slot(5);
        chk("w5_kc", kc_I, 8'h4A);

        // Write slot 7 while cnt=7 stalls one cen
        wait_cnt(7);
        wr_valid = 1'b1; wr_slot = 5'd7; wr_field = 3'd0; wr_data = 7'h11;
        #1 chk("w7_stall", wr_ready, 0);
        tick();
        chk("w7_old_slot", slot_I, 7);
        chk("w7_old_kc", kc_I, 0);
        chk("w7_accept", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        wait_slot(7);
        chk("w7_kc", kc_I, 8'h11);

        // Remaining fields, including an unused field code
        do_write(12, 1, 7'h2D);
        do_write(13, 3, 7'h03);
        do_write(14, 4, 7'h06);
        do_write(15, 6, 7'h55);
        do_write(3, 2, 7'h53);
        wait_slot(12); chk("w12_kf", kf_I, 8'h2D);
        wait_slot(13); chk("w13_dt2", dt2_I, 3);
        wait_slot(14); chk("w14_pms", pms_I, 6);
        wait_slot(15); chk("w15_kc", kc_I, 0);

        // dt1/mul alignment for slot 3
        wait_slot(3);
        tick();
        chk("s3_dt1_II", dt1_II, 5);
        repeat (4) tick();
        chk("s3_mul_VI", mul_VI, 3);

        // Key-on slot 9: two rounds of reset, then none
        wait_cnt(20);
        keyon_req = 1'b1; keyon_slot = 5'd9;
        tick();
        keyon_req = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wait_slot(9);
            tick(); tick();
            chk("ko9_pg", pg_rst_III, (r < 2) ? 1 : 0);
        end

        // Key-on coincident with cnt, then reset mid-round
        wait_cnt(4);
        keyon_req = 1'b1; keyon_slot = 5'd4;
        tick();
        keyon_req = 1'b0;
        chk("ko4_slot", slot_I, 4);
        tick(); tick();
        chk("ko4_pg", pg_rst_III, 1);
        wait_cnt(10);
        keyon_req = 1'b1; keyon_slot = 5'd25;
        tick();
        keyon_req = 1'b0;
        wait_cnt(15);
        wr_valid = 1'b1; wr_slot = 5'd22; wr_field = 3'd0; wr_data = 7'h33;
        rst_n = 1'b0;
        model_reset();
        #1 chk("rst_pg", pg_rst_III, 0);
        chk("rst_slot", slot_I, 0);
        repeat (2) tick();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_slot", slot_I, 0);
        chk("post_rst_zero", zero, 1);
        pulses = 0;
        repeat (70) begin
            tick();
            if (pg_rst_III) pulses++;
        end
        chk("post_rst_pulses", pulses, 0);
        wait_slot(5);
        chk("post_rst_kc5", kc_I, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jt51_pg_slot_ctrl.md
JT51_PG_SLOT_CTRL -- requirements
Module: jt51_pg_slot_ctrl

Interface
REQ-001 SHALL have parameter: PG_RST_ROUNDS, default 1, number of consecutive 32-slot rounds pg_rst_III is held per key-on (legal 1..3).
REQ-002 SHALL have ports: clk, input, 1, single clock; rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port: cen, input, 1, clock enable; all state advances only when high.
REQ-004 SHALL have ports: wr_valid in 1, wr_ready out 1, wr_slot in 5, wr_field in 3, wr_data in 7; parameter write channel.
REQ-005 SHALL have ports: keyon_req in 1, keyon_slot in 5; key-on request strobe, sampled when cen is high.
REQ-006 SHALL have ports: zero out 1, slot_I out 5, kc_I out 7, kf_I out 6, dt2_I out 2, pms_I out 3; stage-I operator parameters.
REQ-007 SHALL have ports: dt1_II out 3, mul_VI out 4, pg_rst_III out 1; stage-aligned PG controls.

Function
REQ-008 SHALL keep a 5-bit slot counter cnt that increments by 1 per cen, wrapping 31->0.
REQ-009 SHALL hold a 32-entry parameter store indexed by slot: kc[6:0], kf[5:0], dt1[2:0], mul[3:0], dt2[1:0], pms[2:0].
REQ-010 SHALL, on each cen, register slot_I<=cnt and kc_I/kf_I/dt2_I/pms_I<=store[cnt] (latency 1 cen).
REQ-011 SHALL drive zero high exactly while slot_I==0.
REQ-012 SHALL present dt1_II as store[slot].dt1 delayed 1 cen and mul_VI delayed 5 cens after that slot's stage-I outputs.
REQ-013 SHALL present pg_rst_III for a slot 2 cens after that slot's stage-I outputs.
REQ-014 SHALL drive wr_ready = cen AND (wr_slot != cnt); a write to the slot being read this cycle stalls one cen.
REQ-015 SHALL commit a write only when wr_valid && wr_ready; field map: 0 kc=wr_data[6:0]; 1 kf=wr_data[5:0]; 2 {dt1,mul}=wr_data[6:0]; 3 dt2=wr_data[1:0]; 4 pms=wr_data[2:0]; 5..7 acknowledged, no effect.
REQ-016 SHALL keep a per-slot 2-bit pending counter; keyon_req loads keyon_slot's counter with PG_RST_ROUNDS.
REQ-017 SHALL, when cnt reaches a slot with nonzero counter, assert that slot's pg_rst_III and decrement the counter.
REQ-018 SHALL, for keyon_req on the slot being read that cycle, issue pg_rst in that round and load PG_RST_ROUNDS-1 remaining (reload wins over decrement).
REQ-019 SHALL ignore keyon_req and wr_valid while cen is low; wr_ready is low then.

Reset
REQ-020 SHALL, on rst_n low, clear asynchronously: cnt, parameter store, pending counters, delay lines; all outputs 0, wr_ready 0.
REQ-021 SHALL, after rst_n rises, output slot 0 at the first cen, zero high.
REQ-022 SHALL discard in-flight writes and pending key-ons on reset mid-round; no pg_rst_III pulse survives reset.

Configuration
REQ-023 SHALL, with JT51_PGCTL_READBACK_EN defined, add rd_slot in 5, rd_field in 3, rd_data out 7: registered 1-cycle readback of the store using the REQ-015 field map (fields 5..7 read 0).
REQ-024 SHALL, without JT51_PGCTL_READBACK_EN, omit those ports and logic entirely.

Structure
REQ-025 SHALL place field codes, per-field widths, slot count (32) and stage offsets (II=1, III=2, VI=5) in shared package jt51_pg_pkg.
REQ-026 SHALL implement the mul/dt1/pg_rst alignment with the existing jt51_sh delay-line sub-module (one instance per width); no other sub-modules.

Verification
REQ-027 SHALL test: reset, cen=1 steady -> slot_I 0,1..31,0; zero high every 32nd cycle; all params 0.
REQ-028 SHALL test: write slot 5 field 0 data 0x4A while cnt=10 -> wr_ready=1; next round slot_I=5 shows kc_I=0x4A.
REQ-029 SHALL test: write slot 7 while cnt=7 -> wr_ready=0 that cycle; accepted next cen; no torn value on slot 7.
REQ-030 SHALL test: field 2 data 0x53 to slot 3 -> dt1_II=3'b101 1 cen, mul_VI=4'h3 5 cens after slot_I=3.
REQ-031 SHALL test: PG_RST_ROUNDS=2, keyon_req slot 9 -> pg_rst_III high 2 cens after slot_I=9 in two consecutive rounds, then low.
REQ-032 SHALL test: keyon_req slot 4 coincident with cnt=4, then rst_n pulse mid-round -> pulse issued that round, none after reset.
